// File: rtl/pending_bitmap_serializer_if.sv
// Handshake bundle for the pending-bitmap serializer: vector input side,
// index output side, flush and busy status.
interface pending_bitmap_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_vec;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_valid, in_vec, flush, out_ready,
    input  in_ready, out_valid, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_vec, flush, out_ready,
    output in_ready, out_valid, out_idx, out_last, busy
  );
endinterface

// File: rtl/pending_bitmap_serializer.sv
// Accepts a multi-hot request vector and emits the index of each set bit,
// lowest first, one per output transfer.
module pending_bitmap_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pending_bitmap_serializer_if.slave    bus
);
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  state_e           state_c;
  logic [IW-1:0]    idx_c;
  logic             last_c;
  logic             in_ready_c;
  logic             in_fire_c;
  logic             out_fire_c;

  // The pending register is the whole state: empty means idle.
  assign state_c = (pending_q != '0) ? ST_DRAIN : ST_IDLE;

  // Lowest set bit wins because lower indices overwrite higher ones.
  always_comb begin
    idx_c = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pending_q[i]) idx_c = IW'(i);
    end
  end

  // Exactly one bit set: clearing the lowest bit leaves nothing behind.
  assign last_c = (state_c == ST_DRAIN) &&
                  ((pending_q & (pending_q - WIDTH'(1))) == '0);

  assign out_fire_c = (state_c == ST_DRAIN) && bus.out_ready;
  assign in_ready_c = !bus.flush &&
                      ((state_c == ST_IDLE) || (out_fire_c && last_c));
  assign in_fire_c  = bus.in_valid && in_ready_c;

  // Flush beats load, load beats drain; x & (x-1) drops the emitted bit.
  always_comb begin
    pending_d = pending_q;
    if (bus.flush) begin
      pending_d = '0;
    end else if (in_fire_c) begin
      pending_d = bus.in_vec;
    end else if (out_fire_c) begin
      pending_d = pending_q & (pending_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign bus.out_valid = (state_c == ST_DRAIN);
  assign bus.busy      = (state_c == ST_DRAIN);
  assign bus.out_idx   = idx_c;
  assign bus.out_last  = last_c;
  assign bus.in_ready  = in_ready_c;

endmodule
